// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register busy tracking, in-flight limit and flush for issue.
// Optional SB_RET_BYPASS_EN: a same-cycle retire clears its register's hazard.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic [4:0]  dec_rd_i,
  input  logic        dec_use_rs1_i,
  input  logic        dec_use_rs2_i,
  input  logic        dec_we_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  input  logic        ret_valid_i,
  input  logic        ret_we_i,
  input  logic [4:0]  ret_rd_i,
  input  logic        flush_i,
  output logic [31:0] busy_o,
  output logic [3:0]  inflight_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  localparam logic [3:0] MAXC = 4'(MAX_INFLIGHT);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic [31:0] avail;
  logic [31:0] clr;
  logic [31:0] set;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        hazard;
  logic        full;
  logic        fire;
  logic        ret_ok;

  always_comb begin
    avail = busy;
`ifdef SB_RET_BYPASS_EN
    if (ret_valid_i && ret_we_i) avail[ret_rd_i] = 1'b0;
`endif
    hazard = (dec_use_rs1_i && avail[dec_rs1_i])
          || (dec_use_rs2_i && avail[dec_rs2_i])
          || (dec_we_i && avail[dec_rd_i]);
  end

  assign full          = (cnt == MAXC);
  assign issue_valid_o = dec_valid_i && !hazard && !full
                      && (state == RUN);
  assign dec_ready_o   = issue_valid_o && issue_ready_i;
  assign fire          = dec_ready_o;
  assign stall_o       = dec_valid_i && (hazard || full)
                      && (state != FLUSH);
  // Retires with nothing in flight belong to squashed work.
  assign ret_ok        = ret_valid_i && (cnt != 4'd0)
                      && (state != FLUSH);

  always_comb begin
    clr = '0;
    set = '0;
    if (ret_ok && ret_we_i) clr[ret_rd_i] = 1'b1;
    if (fire && dec_we_i) set[dec_rd_i] = 1'b1;
    busy_nxt = ((busy & ~clr) | set) & 32'hFFFF_FFFE;
    cnt_nxt  = cnt + 4'(fire) - 4'(ret_ok);
    if (state == FLUSH) state_nxt = RUN;
    else if (stall_o) state_nxt = STALL;
    else state_nxt = RUN;
    if (flush_i) begin
      busy_nxt  = '0;
      cnt_nxt   = '0;
      state_nxt = FLUSH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      busy  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy_o     = busy;
  assign inflight_o = cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus random traffic
// against a behavioural scoreboard model checked every cycle.
module tb_issue_scoreboard;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid_i = 1'b0;
  logic        dec_ready_o;
  logic [4:0]  dec_rs1_i = '0;
  logic [4:0]  dec_rs2_i = '0;
  logic [4:0]  dec_rd_i = '0;
  logic        dec_use_rs1_i = 1'b0;
  logic        dec_use_rs2_i = 1'b0;
  logic        dec_we_i = 1'b0;
  logic        issue_valid_o;
  logic        issue_ready_i = 1'b0;
  logic        ret_valid_i = 1'b0;
  logic        ret_we_i = 1'b0;
  logic [4:0]  ret_rd_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] busy_o;
  logic [3:0]  inflight_o;
  logic        stall_o;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rd_i(dec_rd_i), .dec_use_rs1_i(dec_use_rs1_i),
    .dec_use_rs2_i(dec_use_rs2_i), .dec_we_i(dec_we_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .ret_valid_i(ret_valid_i), .ret_we_i(ret_we_i),
    .ret_rd_i(ret_rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .inflight_o(inflight_o), .stall_o(stall_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: set of pending destination registers, an in-flight
  // count, and two flags for "waiting on hazard" and "flushing".
  bit m_busy[32];
  int m_inf = 0;
  bit m_stalled = 1'b0;
  bit m_flushing = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit blk(input logic [4:0] r);
    bit b;
    b = (r != 5'd0) && m_busy[r];
`ifdef SB_RET_BYPASS_EN
    if (ret_valid_i && ret_we_i && ret_rd_i == r) b = 1'b0;
`endif
    return b;
  endfunction

  always @(negedge clk) begin
    logic [31:0] bv;
    bit hz, fl, ev, er, es, rt;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_inf = 0;
      m_stalled = 1'b0;
      m_flushing = 1'b0;
    end else begin
      hz = (dec_use_rs1_i && blk(dec_rs1_i))
        || (dec_use_rs2_i && blk(dec_rs2_i))
        || (dec_we_i && blk(dec_rd_i));
      fl = (m_inf == MAXI);
      ev = dec_valid_i && !hz && !fl && !m_stalled && !m_flushing;
      er = ev && issue_ready_i;
      es = dec_valid_i && (hz || fl) && !m_flushing;
      for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
      chk("issue_valid", 32'(issue_valid_o), 32'(ev));
      chk("dec_ready", 32'(dec_ready_o), 32'(er));
      chk("stall", 32'(stall_o), 32'(es));
      chk("busy", busy_o, bv);
      chk("inflight", 32'(inflight_o), 32'(m_inf));
      if (flush_i) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_inf = 0;
        m_flushing = 1'b1;
        m_stalled = 1'b0;
      end else if (m_flushing) begin
        m_flushing = 1'b0;
      end else begin
        rt = ret_valid_i && (m_inf > 0);
        if (rt && ret_we_i && ret_rd_i != 5'd0) m_busy[ret_rd_i] = 1'b0;
        if (er && dec_we_i && dec_rd_i != 5'd0) m_busy[dec_rd_i] = 1'b1;
        m_inf = m_inf + (er ? 1 : 0) - (rt ? 1 : 0);
        m_stalled = es;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic we);
    dec_valid_i = v;
    dec_rs1_i = r1;
    dec_rs2_i = r2;
    dec_rd_i = rd;
    dec_use_rs1_i = u1;
    dec_use_rs2_i = u2;
    dec_we_i = we;
  endtask

  task automatic ret(input logic v, input logic we,
                     input logic [4:0] rd);
    ret_valid_i = v;
    ret_we_i = we;
    ret_rd_i = rd;
  endtask

  task automatic idle();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ret(1'b0, 1'b0, 5'd0);
    flush_i = 1'b0;
  endtask

  task automatic flush_all();
    idle();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
  endtask

  task automatic wait_issue(input string nm);
    int n;
    n = 0;
    while (!issue_valid_o && n < 4) begin
      step();
      n++;
    end
    chk(nm, 32'(issue_valid_o), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy_o, 32'h0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_iv", 32'(issue_valid_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    step();
    step();
    rst = 1'b0;
    issue_ready_i = 1'b1;

    // RAW on x5
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    #1 chk("raw_first_iv", 32'(issue_valid_o), 32'd1);
    step();
    dec(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1);
    #1;
    chk("raw_stall", 32'(stall_o), 32'd1);
    chk("raw_iv0", 32'(issue_valid_o), 32'd0);
    step();
    chk("raw_busy", busy_o, 32'h0000_0020);
    ret(1'b1, 1'b1, 5'd5);
    step();
    ret(1'b0, 1'b0, 5'd0);
    wait_issue("raw_issue_after_ret");
    step();
    flush_all();

    // In-flight limit
    for (int k = 0; k < 4; k++) begin
      dec(1'b1, 5'd0, 5'd0, 5'(10 + k), 1'b0, 1'b0, 1'b1);
      step();
    end
    dec(1'b1, 5'd0, 5'd0, 5'd14, 1'b0, 1'b0, 1'b1);
    #1;
    chk("full_inflight", 32'(inflight_o), 32'd4);
    chk("full_stall", 32'(stall_o), 32'd1);
    chk("full_iv0", 32'(issue_valid_o), 32'd0);
    ret(1'b1, 1'b1, 5'd10);
    step();
    ret(1'b0, 1'b0, 5'd0);
    wait_issue("full_issue_after_ret");
    chk("full_inflight_after", 32'(inflight_o), 32'd3);
    step();
    flush_all();

    // Same-cycle set and clear of x7
    dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1);
    step();
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
    ret(1'b1, 1'b1, 5'd7);
    #1 chk("setclr_iv", 32'(issue_valid_o), 32'd1);
    step();
    idle();
    #1;
    chk("setclr_busy", busy_o, 32'h0000_0280);
    chk("setclr_inflight", 32'(inflight_o), 32'd1);
    flush_all();

    // x0 never busy
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    #1;
    chk("x0_busy", busy_o, 32'h0);
    chk("x0_inflight", 32'(inflight_o), 32'd1);
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    chk("x0_read_stall", 32'(stall_o), 32'd0);
    chk("x0_read_iv", 32'(issue_valid_o), 32'd1);
    step();
    flush_all();

    // Flush racing a fire
    for (int k = 5; k < 8; k++) begin
      dec(1'b1, 5'd0, 5'd0, 5'(k), 1'b0, 1'b0, 1'b1);
      step();
    end
    idle();
    #1;
    chk("pre_flush_busy", busy_o, 32'h0000_00E0);
    chk("pre_flush_inflight", 32'(inflight_o), 32'd3);
    dec(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_busy", busy_o, 32'h0);
    chk("flush_inflight", 32'(inflight_o), 32'd0);
    chk("flush_iv", 32'(issue_valid_o), 32'd0);
    chk("flush_stall", 32'(stall_o), 32'd0);
    step();
    chk("post_flush_iv", 32'(issue_valid_o), 32'd1);
    step();

    // Async reset during a stall
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    step();
    dec(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    step();
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy_o, 32'h0);
    chk("arst_inflight", 32'(inflight_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_iv", 32'(issue_valid_o), 32'd1);
    idle();
    step();
    step();
    rst = 1'b0;

    // Random traffic
    repeat (3000) begin
      dec(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      issue_ready_i = 1'($urandom_range(0, 3) != 0);
      ret(1'($urandom_range(0, 4) < 2), 1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)));
      flush_i = 1'($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
